// File: rtl/cp0_exc_ctrl_if.sv
// CP0 exception controller bus: CPU-side strobes, CP0 access and next-PC/squash results.
// The CPU (or bench) drives through master; cp0_exc_ctrl consumes through slave.
interface cp0_exc_ctrl_if;
  logic [31:0] Pc;
  logic        V;
  logic        Ov_chk;
  logic        Syscall;
  logic        Unimpl;
  logic        Intr;
  logic        Mtc0;
  logic        Mfc0;
  logic        Eret;
  logic [4:0]  Rd;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic [1:0]  Pc_sel;
  logic [31:0] Vector;
  logic [31:0] Epc;
  logic        Cancel;
  logic        Inta;

  modport master (
    output Pc, V, Ov_chk, Syscall, Unimpl, Intr, Mtc0, Mfc0, Eret, Rd, Wdata,
    input  Rdata, Pc_sel, Vector, Epc, Cancel, Inta
  );

  modport slave (
    input  Pc, V, Ov_chk, Syscall, Unimpl, Intr, Mtc0, Mfc0, Eret, Rd, Wdata,
    output Rdata, Pc_sel, Vector, Epc, Cancel, Inta
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: Status/Cause/EPC, trap priority, next-PC select.
// Optional Count/Compare timer (IP7) is built when CP0_TIMER_EN is defined.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_BASE    = 32'h0000_0008,
  parameter int          SYNC_STAGES = 2
) (
  input  logic           Clk,
  input  logic           Clrn,
  cp0_exc_ctrl_if.slave  cp0
);

  localparam logic [4:0] RD_COUNT   = 5'd9;
  localparam logic [4:0] RD_COMPARE = 5'd11;
  localparam logic [4:0] RD_STATUS  = 5'd12;
  localparam logic [4:0] RD_CAUSE   = 5'd13;
  localparam logic [4:0] RD_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT    = 5'd0;
  localparam logic [4:0] EXC_SYS    = 5'd8;
  localparam logic [4:0] EXC_RI     = 5'd10;
  localparam logic [4:0] EXC_OV     = 5'd12;

  typedef enum logic {NORMAL, HANDLER} state_e;

  state_e                  state_q, state_d;
  logic                    ie_q, ie_d;
  logic [4:0]              exc_code_q, exc_code_d;
  logic                    ip2_q, ip2_d;
  logic [31:0]             epc_q, epc_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    intr_prev_q;

  logic                    exl;
  logic                    ip7;
  logic                    int_req;
  logic                    evt;
  logic                    int_taken;
  logic [4:0]              evt_code;
  logic                    mtc0_ok;
  logic                    intr_rise;

  assign exl       = (state_q == HANDLER);
  assign int_req   = (ip2_q | ip7) & ie_q & ~exl;
  assign intr_rise = sync_q[SYNC_STAGES-1] & ~intr_prev_q;

  // NOTE: every variable driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    evt       = 1'b1;
    int_taken = 1'b0;
    evt_code  = EXC_INT;
    if (cp0.Unimpl)                evt_code = EXC_RI;
    else if (cp0.Syscall)          evt_code = EXC_SYS;
    else if (cp0.Ov_chk && cp0.V)  evt_code = EXC_OV;
    else if (int_req)              int_taken = 1'b1;
    else                           evt = 1'b0;
  end

  // A trapping instruction never commits its own CP0 write.
  assign mtc0_ok = cp0.Mtc0 & ~evt;

  always_comb begin
    state_d    = state_q;
    ie_d       = ie_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip2_d      = ip2_q;

    if (evt) begin
      state_d    = HANDLER;
      exc_code_d = evt_code;
      if (!exl) epc_d = cp0.Pc;
    end else if (cp0.Eret) begin
      state_d = NORMAL;
    end else if (mtc0_ok) begin
      case (cp0.Rd)
        RD_STATUS: begin
          ie_d    = cp0.Wdata[0];
          state_d = cp0.Wdata[1] ? HANDLER : NORMAL;
        end
        RD_EPC:  epc_d = cp0.Wdata;
        default: ;
      endcase
    end

    if (int_taken || (mtc0_ok && cp0.Rd == RD_CAUSE && !cp0.Wdata[10])) ip2_d = 1'b0;
    // A fresh request landing on the acknowledge edge must not be lost.
    if (intr_rise) ip2_d = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments and cleared asynchronously on Clrn.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q     <= NORMAL;
      ie_q        <= 1'b0;
      exc_code_q  <= 5'd0;
      ip2_q       <= 1'b0;
      epc_q       <= 32'd0;
      sync_q      <= '0;
      intr_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ie_q        <= ie_d;
      exc_code_q  <= exc_code_d;
      ip2_q       <= ip2_d;
      epc_q       <= epc_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], cp0.Intr};
      intr_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ip7_q, ip7_d;

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    ip7_d     = ip7_q;
    if (count_q == compare_q) ip7_d = 1'b1;
    if (mtc0_ok && cp0.Rd == RD_COUNT) count_d = cp0.Wdata;
    if (mtc0_ok && cp0.Rd == RD_COMPARE) begin
      compare_d = cp0.Wdata;
      ip7_d     = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      ip7_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ip7_q     <= ip7_d;
    end
  end

  assign ip7 = ip7_q;
`else
  assign ip7 = 1'b0;
`endif

  always_comb begin
    cp0.Rdata = 32'd0;
    if (Clrn && cp0.Mfc0) begin
      case (cp0.Rd)
        RD_STATUS: cp0.Rdata = {30'd0, exl, ie_q};
        RD_CAUSE:  cp0.Rdata = {16'd0, ip7, 4'd0, ip2_q, 3'd0, exc_code_q, 2'd0};
        RD_EPC:    cp0.Rdata = epc_q;
`ifdef CP0_TIMER_EN
        RD_COUNT:   cp0.Rdata = count_q;
        RD_COMPARE: cp0.Rdata = compare_q;
`endif
        default:   cp0.Rdata = 32'd0;
      endcase
    end
  end

  // Outputs are forced idle while Clrn is held low, whatever the decoder strobes do.
  assign cp0.Pc_sel = !Clrn    ? 2'b00 :
                      evt      ? 2'b01 :
                      cp0.Eret ? 2'b10 : 2'b00;
  assign cp0.Cancel = Clrn & evt;
  assign cp0.Inta   = Clrn & int_taken;
  assign cp0.Vector = EXC_BASE;
  assign cp0.Epc    = epc_q;

endmodule
